// File: rtl/frame_buf_pkg.sv
// Shared types and strobe-level constants for the multi-frame buffer address controller.
package frame_buf_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WRITING = 2'd1,
    SLOT_READY   = 2'd2,
    SLOT_READING = 2'd3
  } slot_st_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } r_state_e;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

endpackage

// File: rtl/frame_slot_alloc.sv
// Slot-state table for the frame buffer: picks the slot to fill, tracks the newest
// completed slot and the slot on display, and retires stale slots.
module frame_slot_alloc
  import frame_buf_pkg::*;
#(
  parameter int NUM_FRAMES = 3,
  parameter int IDX_WIDTH  = $clog2(NUM_FRAMES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 claim,
  input  logic                 commit,
  input  logic                 take,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  output logic                 free_avail,
  output logic [IDX_WIDTH-1:0] free_idx,
  output logic                 ready_valid,
  output logic [IDX_WIDTH-1:0] ready_idx,
  output logic                 reading_valid,
  output logic [IDX_WIDTH-1:0] reading_idx,
  output logic                 frame_drop
);

  slot_st_e slot_st [NUM_FRAMES];

  // Descending scan so the lowest FREE index is the one left standing.
  always_comb begin
    free_avail = DEASSERT_H;
    free_idx   = '0;
    for (int i = NUM_FRAMES - 1; i >= 0; i--) begin
      if (slot_st[i] == SLOT_FREE) begin
        free_avail = ASSERT_H;
        free_idx   = IDX_WIDTH'(i);
      end
    end
  end

  // All decisions use pre-edge state: a slot released this edge is not claimable
  // until the next one, and a take never sees the slot being committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_FRAMES; i++) slot_st[i] <= SLOT_FREE;
      ready_valid   <= DEASSERT_H;
      ready_idx     <= '0;
      reading_valid <= DEASSERT_H;
      reading_idx   <= '0;
      frame_drop    <= DEASSERT_H;
    end else begin
      frame_drop <= commit && ready_valid && !take;
      if (claim) slot_st[free_idx] <= SLOT_WRITING;
      if (commit) begin
        slot_st[wr_idx] <= SLOT_READY;
        if (ready_valid && !take) slot_st[ready_idx] <= SLOT_FREE;
        ready_valid <= ASSERT_H;
        ready_idx   <= wr_idx;
      end else if (take) begin
        ready_valid <= DEASSERT_H;
      end
      if (take) begin
        slot_st[ready_idx] <= SLOT_READING;
        if (reading_valid) slot_st[reading_idx] <= SLOT_FREE;
        reading_valid <= ASSERT_H;
        reading_idx   <= ready_idx;
      end
    end
  end

endmodule

// File: rtl/frame_buf_multi.sv
// Multi-frame address controller: writer fills free slots, reader scans the newest
// completed slot, repeating the last one when nothing new is ready.
module frame_buf_multi
  import frame_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 29,
  parameter int BASE_ADDR  = 2,
  parameter int FRAME_SIZE = 307200,
  parameter int NUM_FRAMES = 3,
  parameter int OFS_WIDTH  = $clog2(FRAME_SIZE),
  parameter int IDX_WIDTH  = $clog2(NUM_FRAMES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_in,
  input  logic                  wr_rdy,
  input  logic                  rd_en_in,
  input  logic                  rd_rdy,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [IDX_WIDTH-1:0]  wr_frame,
  output logic [IDX_WIDTH-1:0]  rd_frame,
  output logic                  frame_rdy,
  output logic                  frame_drop,
  output logic                  frame_repeat,
  output logic [1:0]            dbg_state
);

  localparam longint unsigned SPAN = longint'(BASE_ADDR) + longint'(NUM_FRAMES) * longint'(FRAME_SIZE);
  localparam logic [OFS_WIDTH-1:0]  LAST_OFS   = OFS_WIDTH'(FRAME_SIZE - 1);
  localparam logic [OFS_WIDTH-1:0]  OFS_ONE    = OFS_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(BASE_ADDR);

  if (SPAN > (64'd1 << ADDR_WIDTH)) begin : g_span_err
    $error("frame_buf_multi: frame region does not fit in ADDR_WIDTH");
  end
  if (NUM_FRAMES < 2 || NUM_FRAMES > 4) begin : g_nf_err
    $error("frame_buf_multi: NUM_FRAMES must be 2..4");
  end

  function automatic logic [ADDR_WIDTH-1:0] frame_base(input logic [IDX_WIDTH-1:0] idx);
    return RESET_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(FRAME_SIZE);
  endfunction

  w_state_e w_state;
  r_state_e r_state;
  logic [OFS_WIDTH-1:0] wr_ofs, rd_ofs;
  logic free_avail, ready_valid, shown;
  logic [IDX_WIDTH-1:0] free_idx, ready_idx;
  logic w_claim, w_accept, w_commit, r_take, r_repeat, r_issue;

  // Handshake: a word moves only on a cycle where the active-low strobe is low and
  // the matching rdy is high; the address on the bus during that cycle is the word's.
  assign wr_en = (w_state == W_FILL && wr_en_in == ASSERT_L) ? ASSERT_L : DEASSERT_L;
  assign rd_en = (r_state == R_READ && rd_en_in == ASSERT_L) ? ASSERT_L : DEASSERT_L;

  assign w_claim  = (w_state == W_IDLE) && (wr_en_in == ASSERT_L) && free_avail;
  assign w_accept = (wr_en == ASSERT_L) && wr_rdy;
  assign w_commit = w_accept && (wr_ofs == LAST_OFS);
  assign r_take   = (r_state == R_IDLE) && (rd_en_in == ASSERT_L) && ready_valid;
  assign r_repeat = (r_state == R_IDLE) && (rd_en_in == ASSERT_L) && !ready_valid && shown;
  assign r_issue  = (rd_en == ASSERT_L) && rd_rdy;

  assign dbg_state = {r_state == R_READ, w_state == W_FILL};
  assign frame_rdy = ready_valid;

  frame_slot_alloc #(
    .NUM_FRAMES(NUM_FRAMES),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_alloc (
    .clk          (clk),
    .reset        (reset),
    .claim        (w_claim),
    .commit       (w_commit),
    .take         (r_take),
    .wr_idx       (wr_frame),
    .free_avail   (free_avail),
    .free_idx     (free_idx),
    .ready_valid  (ready_valid),
    .ready_idx    (ready_idx),
    .reading_valid(shown),
    .reading_idx  (rd_frame),
    .frame_drop   (frame_drop)
  );

  // The address holds the last word after a commit; it is reloaded on the next claim.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state  <= W_IDLE;
      wr_frame <= '0;
      wr_ofs   <= '0;
      wr_addr  <= RESET_ADDR;
    end else begin
      case (w_state)
        W_IDLE: if (w_claim) begin
          w_state  <= W_FILL;
          wr_frame <= free_idx;
          wr_ofs   <= '0;
          wr_addr  <= frame_base(free_idx);
        end
        W_FILL: if (w_accept) begin
          if (w_commit) begin
            w_state <= W_IDLE;
          end else begin
            wr_ofs  <= wr_ofs + OFS_ONE;
            wr_addr <= wr_addr + ADDR_ONE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= R_IDLE;
      rd_ofs       <= '0;
      rd_addr      <= RESET_ADDR;
      frame_repeat <= DEASSERT_H;
    end else begin
      frame_repeat <= r_repeat;
      case (r_state)
        R_IDLE: if (r_take || r_repeat) begin
          r_state <= R_READ;
          rd_ofs  <= '0;
          rd_addr <= frame_base(r_take ? ready_idx : rd_frame);
        end
        R_READ: if (r_issue) begin
          if (rd_ofs == LAST_OFS) begin
            r_state <= R_IDLE;
          end else begin
            rd_ofs  <= rd_ofs + OFS_ONE;
            rd_addr <= rd_addr + ADDR_ONE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buf_multi.sv
// Directed bench for frame_buf_multi: 3-slot instance for the main flows and a
// 2-slot instance for the writer stall.
module tb_frame_buf_multi;

  localparam int FS   = 8;
  localparam int AW   = 29;
  localparam int BASE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 3-slot instance
  logic wr_en_in = 1'b1, wr_rdy = 1'b0, rd_en_in = 1'b1, rd_rdy = 1'b0;
  logic wr_en, rd_en, frame_rdy, frame_drop, frame_repeat;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0] wr_frame, rd_frame, dbg_state;

  // 2-slot instance
  logic b_wr_en_in = 1'b1, b_wr_rdy = 1'b0, b_rd_en_in = 1'b1, b_rd_rdy = 1'b0;
  logic b_wr_en, b_rd_en, b_frame_rdy, b_frame_drop, b_frame_repeat;
  logic [AW-1:0] b_wr_addr, b_rd_addr;
  logic [0:0] b_wr_frame, b_rd_frame;
  logic [1:0] b_dbg_state;

  int checks = 0;
  int failures = 0;

  frame_buf_multi #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_SIZE(FS), .NUM_FRAMES(3)) u_dut (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .wr_rdy(wr_rdy),
    .rd_en_in(rd_en_in), .rd_rdy(rd_rdy), .wr_en(wr_en), .rd_en(rd_en),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_frame(wr_frame), .rd_frame(rd_frame),
    .frame_rdy(frame_rdy), .frame_drop(frame_drop), .frame_repeat(frame_repeat),
    .dbg_state(dbg_state)
  );

  frame_buf_multi #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_SIZE(FS), .NUM_FRAMES(2)) u_dut2 (
    .clk(clk), .reset(reset), .wr_en_in(b_wr_en_in), .wr_rdy(b_wr_rdy),
    .rd_en_in(b_rd_en_in), .rd_rdy(b_rd_rdy), .wr_en(b_wr_en), .rd_en(b_rd_en),
    .wr_addr(b_wr_addr), .rd_addr(b_rd_addr), .wr_frame(b_wr_frame), .rd_frame(b_rd_frame),
    .frame_rdy(b_frame_rdy), .frame_drop(b_frame_drop), .frame_repeat(b_frame_repeat),
    .dbg_state(b_dbg_state)
  );

  task automatic apply_reset();
    reset = 1'b1;
    wr_en_in = 1'b1; rd_en_in = 1'b1; wr_rdy = 1'b0; rd_rdy = 1'b0;
    b_wr_en_in = 1'b1; b_rd_en_in = 1'b1; b_wr_rdy = 1'b0; b_rd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Writes one frame; expects it in slot `slot` with consecutive addresses.
  task automatic do_write(input int slot, input bit rnd);
    int n, cyc, first;
    logic [AW-1:0] exp;
    n = 0; cyc = 0; first = -1;
    exp = AW'(BASE + slot * FS);
    wr_en_in = 1'b0;
    while (n < FS && cyc < 200) begin
      wr_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (wr_en === 1'b0 && first < 0) first = cyc;
      if (wr_en === 1'b0 && wr_rdy) begin
        checks++;
        if (wr_addr !== exp || wr_frame !== 2'(slot)) begin
          failures++;
          $display("FAIL write_word: addr=%0d frame=%0d expected addr=%0d frame=%0d", wr_addr, wr_frame, exp, slot);
        end
        exp++;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    wr_en_in = 1'b1;
    wr_rdy = 1'b0;
    checks++;
    if (n != FS || (!rnd && first != 1)) begin
      failures++;
      $display("FAIL write_frame: words=%0d first_strobe_cycle=%0d expected words=%0d first=1", n, first, FS);
    end
  endtask

  // Reads one frame from slot `slot`; checks the repeat pulse shape.
  task automatic do_read(input int slot, input bit rnd, input bit exp_rep);
    int n, cyc;
    logic [AW-1:0] exp;
    n = 0; cyc = 0;
    exp = AW'(BASE + slot * FS);
    rd_en_in = 1'b0;
    while (n < FS && cyc < 200) begin
      rd_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (frame_repeat !== exp_rep || rd_en !== 1'b0) begin
          failures++;
          $display("FAIL read_start: repeat=%b rd_en=%b expected repeat=%b rd_en=0", frame_repeat, rd_en, exp_rep);
        end
      end
      if (cyc == 2) begin
        checks++;
        if (frame_repeat !== 1'b0) begin
          failures++;
          $display("FAIL repeat_pulse_width: repeat=%b expected 0", frame_repeat);
        end
      end
      if (rd_en === 1'b0 && rd_rdy) begin
        checks++;
        if (rd_addr !== exp || rd_frame !== 2'(slot)) begin
          failures++;
          $display("FAIL read_word: addr=%0d frame=%0d expected addr=%0d frame=%0d", rd_addr, rd_frame, exp, slot);
        end
        exp++;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_en_in = 1'b1;
    rd_rdy = 1'b0;
    checks++;
    if (n != FS) begin
      failures++;
      $display("FAIL read_frame: words=%0d expected %0d", n, FS);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || rd_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_strobes: wr_en=%b rd_en=%b expected 1 1", wr_en, rd_en);
    end
    checks++;
    if (wr_addr !== AW'(BASE) || rd_addr !== AW'(BASE)) begin
      failures++;
      $display("FAIL reset_addr: wr=%0d rd=%0d expected %0d", wr_addr, rd_addr, BASE);
    end
    checks++;
    if (wr_frame !== 2'd0 || rd_frame !== 2'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_frames: wr=%0d rd=%0d dbg=%0d expected 0 0 0", wr_frame, rd_frame, dbg_state);
    end
    checks++;
    if (frame_rdy !== 1'b0 || frame_drop !== 1'b0 || frame_repeat !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: rdy=%b drop=%b rep=%b expected 000", frame_rdy, frame_drop, frame_repeat);
    end
    // Reader with nothing ever shown must stay idle.
    rd_en_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || frame_repeat !== 1'b0) begin
      failures++;
      $display("FAIL read_before_first_frame: rd_en=%b rep=%b expected 1 0", rd_en, frame_repeat);
    end
    rd_en_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_write(0, 1'b0);
    @(negedge clk);
    checks++;
    if (frame_rdy !== 1'b1 || frame_drop !== 1'b0) begin
      failures++;
      $display("FAIL first_commit: rdy=%b drop=%b expected 1 0", frame_rdy, frame_drop);
    end
    @(posedge clk); #1;
    do_read(0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (frame_rdy !== 1'b0) begin
      failures++;
      $display("FAIL rdy_after_take: rdy=%b expected 0", frame_rdy);
    end
    @(posedge clk); #1;
    do_read(0, 1'b0, 1'b1);
  endtask

  task automatic test_drop();
    apply_reset();
    do_write(0, 1'b0);
    @(negedge clk);
    checks++;
    if (frame_drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_first_commit: drop=%b expected 0", frame_drop);
    end
    @(posedge clk); #1;
    do_write(1, 1'b0);
    @(negedge clk);
    checks++;
    if (frame_drop !== 1'b1 || frame_rdy !== 1'b1) begin
      failures++;
      $display("FAIL drop_second_commit: drop=%b rdy=%b expected 1 1", frame_drop, frame_rdy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (frame_drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_pulse_width: drop=%b expected 0", frame_drop);
    end
    @(posedge clk); #1;
    do_read(1, 1'b0, 1'b0);
    do_write(0, 1'b0);
  endtask

  task automatic test_random();
    do_write(2, 1'b1);
    @(negedge clk);
    checks++;
    if (frame_drop !== 1'b1) begin
      failures++;
      $display("FAIL random_drop: drop=%b expected 1", frame_drop);
    end
    @(posedge clk); #1;
    do_read(2, 1'b1, 1'b0);
    do_read(2, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    wr_en_in = 1'b0;
    wr_rdy = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_addr !== AW'(BASE + 4) || wr_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_frame_offset4: addr=%0d wr_en=%b expected %0d 0", wr_addr, wr_en, BASE + 4);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== AW'(BASE) || wr_frame !== 2'd0 || rd_frame !== 2'd0 ||
        rd_addr !== AW'(BASE) || frame_rdy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_frame_reset: wr_en=%b wr_addr=%0d wr_frame=%0d rd_frame=%0d rd_addr=%0d rdy=%b dbg=%0d expected 1 %0d 0 0 %0d 0 0",
               wr_en, wr_addr, wr_frame, rd_frame, rd_addr, frame_rdy, dbg_state, BASE, BASE);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    wr_en_in = 1'b1;
    wr_rdy = 1'b0;
    do_write(0, 1'b0);
  endtask

  task automatic test_stall();
    apply_reset();
    b_wr_rdy = 1'b1;
    b_rd_rdy = 1'b1;
    b_wr_en_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 b_wr_en_in = 1'b1;
    b_rd_en_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 b_rd_en_in = 1'b1;
    b_wr_en_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 b_wr_en_in = 1'b1;
    @(negedge clk);
    checks++;
    if (b_wr_frame !== 1'b1 || b_frame_rdy !== 1'b1 || b_rd_frame !== 1'b0) begin
      failures++;
      $display("FAIL stall_setup: wr_frame=%0d rdy=%b rd_frame=%0d expected 1 1 0", b_wr_frame, b_frame_rdy, b_rd_frame);
    end
    @(posedge clk); #1;
    b_wr_en_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (b_wr_en !== 1'b1 || b_dbg_state[0] !== 1'b0) begin
        failures++;
        $display("FAIL stall_no_free: cycle=%0d wr_en=%b dbg=%0d expected wr_en=1 writer idle", i, b_wr_en, b_dbg_state);
      end
      @(posedge clk);
    end
    #1 b_rd_en_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (b_wr_en !== 1'b1 || b_rd_frame !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_same_cycle: wr_en=%b rd_frame=%0d expected 1 1", b_wr_en, b_rd_frame);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (b_wr_en !== 1'b0 || b_wr_frame !== 1'b0 || b_wr_addr !== AW'(BASE)) begin
      failures++;
      $display("FAIL stall_claim_after_release: wr_en=%b frame=%0d addr=%0d expected 0 0 %0d", b_wr_en, b_wr_frame, b_wr_addr, BASE);
    end
    @(posedge clk); #1;
    b_wr_en_in = 1'b1;
    b_rd_en_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_drop();
    test_random();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
